// File: rtl/convnet_pkg.sv
// Shared SRAM-A geometry: size defaults, reader FSM states and the
// bank / address / byte-lane mapping used by both reader and writer.
package convnet_pkg;

   localparam int CH_NUM_D       = 4;
   localparam int ACT_PER_ADDR_D = 4;
   localparam int BW_PER_ACT_D   = 8;
   localparam int IMG_DIM_D      = 28;
   localparam int RADDR_W        = 6;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      DRAIN,
      DONE
   } rd_state_e;

   function automatic logic [1:0] sram_a_bank(
      input logic [7:0] r,
      input logic [7:0] c
   );
      return {r[2], c[0]};
   endfunction

   function automatic logic [RADDR_W-1:0] sram_a_addr(
      input logic [7:0] r,
      input logic [7:0] c
   );
      logic [7:0] a;
      a = ({3'b000, r[7:3]} * 8'd6) + {1'b0, c[7:1]};
      return a[RADDR_W-1:0];
   endfunction

   // Byte lane of pixel p for row phase row; nibbles packed p3..p0.
   function automatic logic [3:0] sram_a_lane(
      input logic [1:0] row,
      input logic [1:0] p
   );
      logic [15:0] t;
      t = 16'h0000;
      unique case (row)
         2'd0: t = 16'hAEBF;
         2'd1: t = 16'h2637;
         2'd2: t = 16'h8C9D;
         2'd3: t = 16'h0415;
         default: t = 16'h0000;
      endcase
      return t[p*4 +: 4];
   endfunction

endpackage

// File: rtl/sram_a_img_reader_if.sv
// Pixel stream handshake between the SRAM-A reader and its consumer.
interface sram_a_img_reader_if #(
   parameter int BW_PER_ACT = 8
) ();

   logic                  out_valid;
   logic                  out_ready;
   logic [BW_PER_ACT-1:0] out_data;
   logic                  out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/sram_a_lane_sel.sv
// Picks the four pixels of one row phase out of a 16-byte SRAM-A word.
module sram_a_lane_sel
   import convnet_pkg::*;
#(
   parameter int CH_NUM       = CH_NUM_D,
   parameter int ACT_PER_ADDR = ACT_PER_ADDR_D,
   parameter int BW_PER_ACT   = BW_PER_ACT_D
) (
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] word,
   input  logic [1:0]                                row,
   output logic [3:0][BW_PER_ACT-1:0]                pix
);

   logic [CH_NUM*ACT_PER_ADDR-1:0][BW_PER_ACT-1:0] lanes;

   assign lanes = word;

   always_comb begin
      pix = '0;
      for (int p = 0; p < 4; p++) begin
         pix[p] = lanes[sram_a_lane(row, 2'(p))];
      end
   end

endmodule

// File: rtl/sram_a_img_reader.sv
// Streams one IMG_DIM x IMG_DIM image out of SRAM-A in raster order.
// Define SRAM_A_READER_PREFETCH_EN to overlap the next group read with the drain.
module sram_a_img_reader
   import convnet_pkg::*;
#(
   parameter int CH_NUM       = CH_NUM_D,
   parameter int ACT_PER_ADDR = ACT_PER_ADDR_D,
   parameter int BW_PER_ACT   = BW_PER_ACT_D,
   parameter int IMG_DIM      = IMG_DIM_D
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a0,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a1,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a2,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a3,
   output logic [RADDR_W-1:0] sram_raddr_a0,
   output logic [RADDR_W-1:0] sram_raddr_a1,
   output logic [RADDR_W-1:0] sram_raddr_a2,
   output logic [RADDR_W-1:0] sram_raddr_a3,
   sram_a_img_reader_if.master out_if,
   output logic busy,
   output logic done
);

   localparam int WORD_W = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
   localparam logic [7:0] R_MAX = 8'(IMG_DIM - 1);
   localparam logic [7:0] C_MAX = 8'(IMG_DIM / 4 - 1);

`ifdef SRAM_A_READER_PREFETCH_EN
   localparam rd_state_e GRP_NEXT = DRAIN;
`else
   localparam rd_state_e GRP_NEXT = FETCH;
`endif

   typedef logic [3:0][BW_PER_ACT-1:0] grp_t;

   rd_state_e state, nstate;

   logic [7:0]         fr, fc;
   logic [RADDR_W-1:0] raddr;
   logic [1:0]         rbank, rrow;
   logic               rlast;
   grp_t               cbuf, sel_pix;
   logic               clast;
   logic [1:0]         px;
   logic [WORD_W-1:0]  word;
   logic               hs, grp_end, issue, f_last;

`ifdef SRAM_A_READER_PREFETCH_EN
   grp_t nbuf;
   logic nlast;
   logic pf_p1, pf_p2;
`endif

   assign hs      = out_if.out_valid && out_if.out_ready;
   assign grp_end = hs && (px == 2'd3);
   assign f_last  = (fr == R_MAX) && (fc == C_MAX);

   assign sram_raddr_a0 = raddr;
   assign sram_raddr_a1 = raddr;
   assign sram_raddr_a2 = raddr;
   assign sram_raddr_a3 = raddr;

   // rbank tracks the outstanding read, not the fetch counter.
   always_comb begin
      word = sram_rdata_a0;
      unique case (rbank)
         2'd0: word = sram_rdata_a0;
         2'd1: word = sram_rdata_a1;
         2'd2: word = sram_rdata_a2;
         2'd3: word = sram_rdata_a3;
         default: word = sram_rdata_a0;
      endcase
   end

   sram_a_lane_sel #(
      .CH_NUM      (CH_NUM),
      .ACT_PER_ADDR(ACT_PER_ADDR),
      .BW_PER_ACT  (BW_PER_ACT)
   ) u_lane_sel (
      .word(word),
      .row (rrow),
      .pix (sel_pix)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:  if (start) nstate = FETCH;
         FETCH: nstate = WAIT;
         WAIT:  nstate = DRAIN;
         DRAIN: if (grp_end) nstate = clast ? DONE : GRP_NEXT;
         DONE:  nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      out_if.out_valid = (state == DRAIN);
      out_if.out_data  = cbuf[px];
      out_if.out_last  = (state == DRAIN) && clast && (px == 2'd3);
      busy = (state == FETCH) || (state == WAIT) || (state == DRAIN);
      done = (state == DONE);
   end

   always_comb begin
      issue = 1'b0;
      unique case (state)
         IDLE:  issue = start;
`ifdef SRAM_A_READER_PREFETCH_EN
         WAIT:  issue = !rlast;
         DRAIN: issue = grp_end && !clast && !nlast;
`else
         DRAIN: issue = grp_end && !clast;
`endif
         default: issue = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fr    <= '0;
         fc    <= '0;
         raddr <= '0;
         rbank <= '0;
         rrow  <= '0;
         rlast <= 1'b0;
         cbuf  <= '0;
         clast <= 1'b0;
         px    <= '0;
`ifdef SRAM_A_READER_PREFETCH_EN
         nbuf  <= '0;
         nlast <= 1'b0;
         pf_p1 <= 1'b0;
         pf_p2 <= 1'b0;
`endif
      end else begin
         if (state == DONE) begin
            fr <= '0;
            fc <= '0;
         end
         if (issue) begin
            raddr <= sram_a_addr(fr, fc);
            rbank <= sram_a_bank(fr, fc);
            rrow  <= fr[1:0];
            rlast <= f_last;
            if (fc == C_MAX) begin
               fc <= '0;
               if (fr != R_MAX) fr <= fr + 8'd1;
            end else begin
               fc <= fc + 8'd1;
            end
         end
         if (state == WAIT) begin
            cbuf  <= sel_pix;
            clast <= rlast;
            px    <= '0;
         end
         if (hs) px <= px + 2'd1;
`ifdef SRAM_A_READER_PREFETCH_EN
         // Read data lands two edges after the address edge.
         pf_p1 <= issue && (state != IDLE);
         pf_p2 <= pf_p1;
         if (pf_p2) begin
            nbuf  <= sel_pix;
            nlast <= rlast;
         end
         if (grp_end && !clast) begin
            cbuf  <= nbuf;
            clast <= nlast;
         end
`endif
      end
   end

endmodule

// File: tb/tb_sram_a_img_reader.sv
// Randomized bench for sram_a_img_reader against a raster-order image model.
module tb_sram_a_img_reader;

   localparam int IMG    = 28;
   localparam int NPIX   = IMG * IMG;
   localparam int NGRP   = NPIX / 4;
   localparam int BUDGET = 6000;

   logic clk = 1'b0;
   logic rst_n, start, busy, done;
   logic [127:0] rdata0, rdata1, rdata2, rdata3;
   logic [5:0]   raddr0, raddr1, raddr2, raddr3;

   logic [15:0][7:0] mem [4][64];

   int n_cmp = 0;
   int n_bad = 0;

   int got_q[$];
   int last_q[$];
   int addr_q[$];
   int done_cnt, done_cyc, first_v, last_hs, eq_bad, reset_hit;

   sram_a_img_reader_if #(.BW_PER_ACT(8)) oif ();

   sram_a_img_reader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .sram_rdata_a0(rdata0),
      .sram_rdata_a1(rdata1),
      .sram_rdata_a2(rdata2),
      .sram_rdata_a3(rdata3),
      .sram_raddr_a0(raddr0),
      .sram_raddr_a1(raddr1),
      .sram_raddr_a2(raddr2),
      .sram_raddr_a3(raddr3),
      .out_if       (oif),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rdata0 <= mem[0][raddr0];
      rdata1 <= mem[1][raddr1];
      rdata2 <= mem[2][raddr2];
      rdata3 <= mem[3][raddr3];
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int spec_lane(input int rm, input int p);
      int tbl [16];
      tbl = '{15, 11, 14, 10, 7, 3, 6, 2, 13, 9, 12, 8, 5, 1, 4, 0};
      return tbl[4'(rm * 4 + p)];
   endfunction

   function automatic int spec_addr(input int r, input int g);
      return 6 * (r / 8) + g / 2;
   endfunction

   task automatic preload();
      int b, a, ln;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 64; j++)
            mem[i][j] = '0;
      for (int r = 0; r < IMG; r++) begin
         for (int c = 0; c < IMG; c++) begin
            b  = ((r / 4) % 2) * 2 + ((c / 4) % 2);
            a  = spec_addr(r, c / 4);
            ln = spec_lane(r % 4, c % 4);
            mem[2'(b)][6'(a)][4'(ln)] = 8'((r * IMG + c) & 255);
         end
      end
   endtask

   task automatic run_frame(input int mode);
      int cyc, stall, post, prev_a, start_a, nbad, p, k;
      bit pulsed, r;
      int exp_a[$];
      got_q.delete();
      last_q.delete();
      addr_q.delete();
      done_cnt = 0;
      done_cyc = -1;
      first_v = -1;
      last_hs = -1;
      eq_bad = 0;
      reset_hit = 0;
      stall = 0;
      post = 0;
      pulsed = 0;
      @(negedge clk);
      prev_a = int'(raddr0);
      start_a = prev_a;
      start = 1'b1;
      oif.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (cyc < BUDGET && post < 3) begin
         if (oif.out_valid && first_v < 0) first_v = cyc;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0) post++;
         if (int'(raddr0) != prev_a) begin
            prev_a = int'(raddr0);
            addr_q.push_back(prev_a);
         end
         if (raddr1 != raddr0 || raddr2 != raddr0 || raddr3 != raddr0)
            eq_bad++;
         r = 1'b1;
         start = 1'b0;
         case (mode)
            1: r = 1'($urandom_range(0, 1));
            2: if (got_q.size() == 3 && stall < 10) begin
                  r = 1'b0;
                  stall++;
                  chk("stall_data", int'(oif.out_data), 3);
                  chk("stall_valid", int'(oif.out_valid), 1);
               end
            3: if (got_q.size() == 50 && !pulsed) begin
                  start = 1'b1;
                  pulsed = 1'b1;
               end
            4: if (got_q.size() == 100) begin
                  rst_n = 1'b0;
                  @(negedge clk);
                  chk("rst_valid", int'(oif.out_valid), 0);
                  chk("rst_busy", int'(busy), 0);
                  rst_n = 1'b1;
                  reset_hit = 1;
                  break;
               end
            default: ;
         endcase
         oif.out_ready = r;
         if (oif.out_valid && r) begin
            got_q.push_back(int'(oif.out_data));
            if (oif.out_last) last_q.push_back(got_q.size() - 1);
            last_hs = cyc + 1;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (mode == 4) begin
         chk("rst_hit", reset_hit, 1);
         return;
      end
      chk("done_seen", int'(done_cyc >= 0), 1);
      nbad = 0;
      for (int i = 0; i < got_q.size() && i < NPIX; i++)
         if (got_q[i] != (((i / IMG) * IMG + i % IMG) & 255)) nbad++;
      chk("npix", got_q.size(), NPIX);
      chk("pix_bad", nbad, 0);
      if (got_q.size() > 4) begin
         chk("first_pix", got_q[0], 0);
         chk("pix4", got_q[4], 4);
      end
      chk("last_cnt", last_q.size(), 1);
      if (last_q.size() > 0) chk("last_pos", last_q[0], NPIX - 1);
      chk("done_cnt", done_cnt, 1);
      chk("done_at", done_cyc, last_hs);
      chk("first_valid", first_v, 2);
      chk("busy_end", int'(busy), 0);
      chk("raddr_eq", eq_bad, 0);
      p = start_a;
      for (int g = 0; g < NGRP; g++) begin
         k = spec_addr(g / (IMG / 4), g % (IMG / 4));
         if (k != p) exp_a.push_back(k);
         p = k;
      end
      chk("raddr_cnt", addr_q.size(), exp_a.size());
      nbad = 0;
      for (int i = 0; i < addr_q.size() && i < exp_a.size(); i++)
         if (addr_q[i] != exp_a[i]) nbad++;
      chk("raddr_seq", nbad, 0);
      if (mode == 0) begin
`ifdef SRAM_A_READER_PREFETCH_EN
         chk("frame_time", int'(last_hs <= NPIX + 3), 1);
`else
         chk("frame_time",
             int'(last_hs >= NGRP * 6 && last_hs <= NGRP * 6 + 3), 1);
`endif
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      oif.out_ready = 1'b0;
      preload();
      repeat (3) @(negedge clk);
      chk("rst_out_valid", int'(oif.out_valid), 0);
      chk("rst_out_last", int'(oif.out_last), 0);
      chk("rst_out_data", int'(oif.out_data), 0);
      chk("rst_busy0", int'(busy), 0);
      chk("rst_done0", int'(done), 0);
      chk("rst_raddr", int'(raddr0), 0);
      rst_n = 1'b1;
      run_frame(0);
      run_frame(1);
      run_frame(2);
      run_frame(3);
      run_frame(4);
      run_frame(0);
      run_frame(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
